// File: rtl/alu_pkg.sv
// ALU controller shared definitions: opcodes, FSM states,
// instruction header field offsets and a decode helper.
package alu_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_LDI  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOTA = 4'b0111;

    // Header sits above the immediate: {opcode, dst, srca, srcb}
    localparam int HDR_W    = 10;
    localparam int OPC_LSB  = 6;
    localparam int DST_LSB  = 4;
    localparam int SRCA_LSB = 2;
    localparam int SRCB_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_e;

    function automatic logic is_alu_op(input logic [3:0] opc);
        logic r;
        r = 1'b0;
        case (opc)
            OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_XOR, OP_NOTA: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Instruction offer/accept handshake between an issuer
// (master) and the ALU controller (slave).
interface alu_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             INSTR_VALID;
    logic [WIDTH+9:0] INSTR;
    logic             INSTR_READY;

    modport master (
        output INSTR_VALID,
        output INSTR,
        input  INSTR_READY
    );

    modport slave (
        input  INSTR_VALID,
        input  INSTR,
        output INSTR_READY
    );
endinterface

// File: rtl/alu_regfile.sv
// Four-entry register file: one synchronous write port,
// two combinational read ports, cleared by reset.
module alu_regfile #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             we_i,
    input  logic [1:0]       waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [1:0]       raddr_a_i,
    input  logic [1:0]       raddr_b_i,
    output logic [WIDTH-1:0] rdata_a_o,
    output logic [WIDTH-1:0] rdata_b_o
);

    logic [WIDTH-1:0] regs_q [4];

    // Register storage with synchronous clear
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu_ctrl.sv
// ALU sequencing controller: accepts instructions, drives an
// external ALU through ISSUE/WAIT/WB and writes results back.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 2
) (
    input  logic             CLK,
    input  logic             RST,
    alu_ctrl_if.slave        ibus,
    output logic             ALU_EN,
    output logic             ALU_OE,
    output logic [3:0]       ALU_OPCODE,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    input  logic [WIDTH-1:0] ALU_OUT,
    input  logic             CF,
    input  logic             OF,
    input  logic             SF,
    input  logic             ZF,
    output logic             RES_VALID,
    output logic [WIDTH-1:0] RES,
    output logic [3:0]       FLAGS,
    output logic             ERR,
    output logic             BUSY
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam int LOAD = (ALU_LAT > 1) ? ALU_LAT - 2 : 0;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       opc_q, opc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       dst_q, dst_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       flags_q, flags_d;
    logic             rv_q, rv_d;
    logic             err_q, err_d;

    logic [HDR_W-1:0] hdr;
    logic [3:0]       in_opc;
    logic [1:0]       in_dst;
    logic [1:0]       in_srca;
    logic [1:0]       in_srcb;
    logic [WIDTH-1:0] in_imm;
    logic             xfer;

    logic             rf_we;
    logic [1:0]       rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    assign hdr     = ibus.INSTR[WIDTH +: HDR_W];
    assign in_opc  = hdr[OPC_LSB +: 4];
    assign in_dst  = hdr[DST_LSB +: 2];
    assign in_srca = hdr[SRCA_LSB +: 2];
    assign in_srcb = hdr[SRCB_LSB +: 2];
    assign in_imm  = ibus.INSTR[WIDTH-1:0];

    assign ibus.INSTR_READY = (state_q == ST_IDLE);
    assign xfer = ibus.INSTR_VALID && ibus.INSTR_READY;

    alu_regfile #(
        .WIDTH (WIDTH)
    ) u_rf (
        .CLK       (CLK),
        .RST       (RST),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (in_srca),
        .raddr_b_i (in_srcb),
        .rdata_a_o (rd_a),
        .rdata_b_o (rd_b)
    );

    // Next state, operand latching, write-back and result pulses
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opc_d    = opc_q;
        a_d      = a_q;
        b_d      = b_q;
        dst_d    = dst_q;
        res_d    = res_q;
        flags_d  = flags_q;
        rv_d     = 1'b0;
        err_d    = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = dst_q;
        rf_wdata = ALU_OUT;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (is_alu_op(in_opc)) begin
                        state_d = ST_ISSUE;
                        opc_d   = in_opc;
                        a_d     = rd_a;
                        b_d     = rd_b;
                        dst_d   = in_dst;
                    end else if (in_opc == OP_LDI) begin
                        rf_we    = 1'b1;
                        rf_waddr = in_dst;
                        rf_wdata = in_imm;
                        res_d    = in_imm;
                        rv_d     = 1'b1;
                    end else if (in_opc != OP_NOP) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (ALU_LAT > 1) begin
                    state_d = ST_WAIT;
                    cnt_d   = CW'(LOAD);
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_WB;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                res_d   = ALU_OUT;
                flags_d = {CF, OF, SF, ZF};
                rv_d    = 1'b1;
                opc_d   = '0;
                a_d     = '0;
                b_d     = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            opc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            dst_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opc_q   <= opc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dst_q   <= dst_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
        end
    end

    assign BUSY       = (state_q != ST_IDLE);
    assign ALU_EN     = BUSY;
    assign ALU_OE     = BUSY;
    assign ALU_OPCODE = opc_q;
    assign ALU_A      = a_q;
    assign ALU_B      = b_q;
    assign RES        = res_q;
    assign FLAGS      = flags_q;
    assign RES_VALID  = rv_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: team ALU with OE-gated output, directed
// scenarios, then random instructions against a reference model.
module tb_alu_ctrl;
    import alu_pkg::*;

    localparam int W   = 8;
    localparam int LAT = 2;
    localparam int K_NONE = 0;
    localparam int K_LDI  = 1;
    localparam int K_ALU  = 2;
    localparam int K_ERR  = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         alu_en, alu_oe;
    logic [3:0]   alu_opc;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic         cf, of, sf, zf;
    logic         res_valid, err, busy;
    logic [W-1:0] res;
    logic [3:0]   flags;

    int total = 0;
    int bad = 0;

    logic [W-1:0] rf [4];
    logic [3:0]   mflags;

    alu_ctrl_if #(.WIDTH(W)) bus ();

    alu_ctrl #(.WIDTH(W), .ALU_LAT(LAT)) dut (
        .CLK        (clk),
        .RST        (rst),
        .ibus       (bus),
        .ALU_EN     (alu_en),
        .ALU_OE     (alu_oe),
        .ALU_OPCODE (alu_opc),
        .ALU_A      (alu_a),
        .ALU_B      (alu_b),
        .ALU_OUT    (alu_out),
        .CF         (cf),
        .OF         (of),
        .SF         (sf),
        .ZF         (zf),
        .RES_VALID  (res_valid),
        .RES        (res),
        .FLAGS      (flags),
        .ERR        (err),
        .BUSY       (busy)
    );

    always #5 clk = ~clk;

    // Team ALU: combinational result, output and flags gated by OE
    logic [W:0]   ext;
    logic [W-1:0] y;
    logic         c, o;
    always_comb begin
        ext = '0;
        y = '0;
        c = 1'b0;
        o = 1'b0;
        case (alu_opc)
            OP_ADD: begin
                ext = {1'b0, alu_a} + {1'b0, alu_b};
                y = ext[W-1:0];
                c = ext[W];
                o = (alu_a[W-1] == alu_b[W-1]) && (y[W-1] != alu_a[W-1]);
            end
            OP_SUB: begin
                ext = {1'b0, alu_a} - {1'b0, alu_b};
                y = ext[W-1:0];
                c = ext[W];
                o = (alu_a[W-1] != alu_b[W-1]) && (y[W-1] != alu_a[W-1]);
            end
            OP_AND:  y = alu_a & alu_b;
            OP_OR:   y = alu_a | alu_b;
            OP_XOR:  y = alu_a ^ alu_b;
            OP_NOTA: y = ~alu_a;
            default: y = '0;
        endcase
        alu_out = alu_oe ? y : '0;
        cf = alu_oe & c;
        of = alu_oe & o;
        sf = alu_oe & y[W-1];
        zf = alu_oe & (y == '0);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: integer arithmetic on the architectural state
    task automatic predict(input logic [3:0] opc, input logic [1:0] d,
                           input logic [1:0] sa, input logic [1:0] sb,
                           input logic [W-1:0] imm, output int kind,
                           output logic [W-1:0] eres,
                           output logic [3:0] efl);
        int a, b, r, m, h;
        bit cc, oo;
        m = 1 << W;
        h = m / 2;
        a = int'(rf[sa]);
        b = int'(rf[sb]);
        r = 0;
        cc = 0;
        oo = 0;
        eres = '0;
        efl = mflags;
        if (opc == OP_NOP) begin
            kind = K_NONE;
        end else if (opc == OP_LDI) begin
            kind = K_LDI;
            rf[d] = imm;
            eres = imm;
        end else if (opc >= 4'd8) begin
            kind = K_ERR;
        end else begin
            kind = K_ALU;
            case (opc)
                OP_ADD: begin
                    r = a + b;
                    cc = (r >= m);
                    r = r % m;
                    oo = ((a >= h) == (b >= h)) && ((r >= h) != (a >= h));
                end
                OP_SUB: begin
                    cc = (a < b);
                    r = (a - b + m) % m;
                    oo = ((a >= h) != (b >= h)) && ((r >= h) != (a >= h));
                end
                OP_AND:  r = a & b;
                OP_OR:   r = a | b;
                OP_XOR:  r = a ^ b;
                default: r = m - 1 - a;
            endcase
            eres = W'(r);
            efl = {cc, oo, (r >= h), (r == 0)};
            rf[d] = eres;
            mflags = efl;
        end
    endtask

    task automatic send(input logic [3:0] opc, input logic [1:0] d,
                        input logic [1:0] sa, input logic [1:0] sb,
                        input logic [W-1:0] imm, input string tag);
        int kind, n, pulses, exp_lat;
        logic [W-1:0] eres;
        logic [3:0] efl;
        predict(opc, d, sa, sb, imm, kind, eres, efl);
        @(negedge clk);
        bus.INSTR_VALID = 1'b1;
        bus.INSTR = {opc, d, sa, sb, imm};
        n = 0;
        while (!bus.INSTR_READY && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/ready"}, 32'(n < 40), 1);
        @(posedge clk);
        @(negedge clk);
        bus.INSTR_VALID = 1'b0;
        n = 1;
        if (kind == K_NONE) begin
            pulses = 0;
            repeat (LAT + 3) begin
                if (res_valid || err) pulses++;
                @(negedge clk);
            end
            chk({tag, "/nop_pulses"}, pulses, 0);
        end else begin
            if (kind == K_ALU) begin
                chk({tag, "/busy"}, {busy, alu_en, alu_oe}, 3'b111);
            end
            while (!(res_valid || err) && n < 20) begin
                @(negedge clk);
                n++;
            end
            exp_lat = (kind == K_ALU) ? LAT + 2 : 1;
            chk({tag, "/latency"}, n, exp_lat);
            if (kind == K_ERR) begin
                chk({tag, "/err"}, {err, res_valid, busy}, 3'b100);
            end else begin
                chk({tag, "/valid"}, {res_valid, err}, 2'b10);
                chk({tag, "/res"}, res, eres);
            end
            chk({tag, "/flags"}, flags, efl);
            @(negedge clk);
            chk({tag, "/pulse_end"}, {res_valid, err}, 2'b00);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy, pulses;
        int k1, k2;
        logic [W-1:0] r1, r2;
        logic [3:0] f1, f2;
        logic [3:0] ropc;
        logic [4:0] pick;

        rst = 1'b1;
        bus.INSTR_VALID = 1'b0;
        bus.INSTR = '0;
        for (int i = 0; i < 4; i++) rf[i] = '0;
        mflags = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst/ctl", {busy, alu_en, alu_oe, res_valid, err}, 5'b0);
        chk("rst/data", {res, flags, alu_opc, alu_a, alu_b}, 0);
        chk("rst/ready", bus.INSTR_READY, 1);
        rst = 1'b0;

        send(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h7F, "ldi_r1");
        send(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h01, "ldi_r2");
        send(OP_ADD, 2'd3, 2'd1, 2'd2, 8'h00, "add_ovf");
        chk("add_ovf/const", {res, flags}, {8'h80, 4'b0110});

        send(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h05, "ldi_r0");
        send(OP_SUB, 2'd1, 2'd0, 2'd0, 8'h00, "sub_zero");
        chk("sub_zero/const", {res, flags}, {8'h00, 4'b0001});
        send(OP_LDI, 2'd2, 2'd0, 2'd0, 8'hAA, "ldi_keep");
        chk("ldi_keep/const", flags, 4'b0001);

        send(4'b1010, 2'd3, 2'd1, 2'd2, 8'hFF, "illegal");
        send(OP_ADD, 2'd3, 2'd0, 2'd2, 8'h00, "post_err");
        send(OP_NOP, 2'd1, 2'd1, 2'd1, 8'h12, "nop");
        send(OP_XOR, 2'd0, 2'd3, 2'd1, 8'h00, "post_nop");

        send(OP_LDI, 2'd1, 2'd0, 2'd0, 8'hF0, "ldi_f0");
        send(OP_NOTA, 2'd2, 2'd1, 2'd0, 8'h00, "nota");
        chk("nota/const", {res, flags}, {8'h0F, 4'b0000});

        // Valid held high across an ALU op: second accepted on IDLE
        predict(OP_ADD, 2'd3, 2'd1, 2'd2, 8'h00, k1, r1, f1);
        predict(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h33, k2, r2, f2);
        @(negedge clk);
        bus.INSTR_VALID = 1'b1;
        bus.INSTR = {OP_ADD, 2'd3, 2'd1, 2'd2, 8'h00};
        chk("hold/ready0", bus.INSTR_READY, 1);
        @(posedge clk);
        @(negedge clk);
        bus.INSTR = {OP_LDI, 2'd0, 2'd0, 2'd0, 8'h33};
        rdy = 0;
        for (int k = 1; k <= LAT + 1; k++) begin
            if (bus.INSTR_READY) rdy++;
            @(negedge clk);
        end
        chk("hold/ready_busy", rdy, 0);
        chk("hold/first", {res_valid, res, flags, bus.INSTR_READY},
            {1'b1, r1, f1, 1'b1});
        @(posedge clk);
        @(negedge clk);
        bus.INSTR_VALID = 1'b0;
        chk("hold/second", {res_valid, res, flags}, {1'b1, r2, f2});

        // Reset while in WAIT abandons the operation
        @(negedge clk);
        bus.INSTR_VALID = 1'b1;
        bus.INSTR = {OP_ADD, 2'd3, 2'd0, 2'd1, 8'h00};
        @(posedge clk);
        @(negedge clk);
        bus.INSTR_VALID = 1'b0;
        @(negedge clk);
        chk("rstwait/in_wait", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstwait/idle", {busy, alu_en, res_valid, alu_opc}, 0);
        pulses = 0;
        repeat (LAT + 3) begin
            @(negedge clk);
            if (res_valid || err) pulses++;
        end
        chk("rstwait/no_wb", pulses, 0);
        chk("rstwait/res", {res, flags}, 0);
        for (int i = 0; i < 4; i++) rf[i] = '0;
        mflags = '0;
        send(OP_OR, 2'd0, 2'd0, 2'd1, 8'h00, "rstwait/r01");
        send(OP_OR, 2'd2, 2'd2, 2'd3, 8'h00, "rstwait/r23");

        for (int i = 0; i < 40; i++) begin
            pick = 5'($urandom_range(0, 21));
            ropc = (pick < 5'd16) ? pick[3:0] : OP_LDI;
            send(ropc, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                 "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
